// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: elastic pipeline register with a 2-entry skid buffer.
//
// Moves a DATA_W-bit payload between two pipeline stages using a valid/ready handshake.
// It keeps the hazard-unit stall and branch flush controls of the fixed IF/ID register it
// replaces. in_ready is driven only by registered state and by stall, so out_ready has no
// combinational path to in_ready. The stage still sustains one transfer per cycle.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add saturating stall/flush counters
// (ports stall_cnt, flush_cnt). With the macro undefined those ports and their logic are absent.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   upstream payload valid
//   in_ready   stage can accept (= ~skid_valid & ~stall)
//   in_data    upstream payload
//   stall      hazard hold: no enqueue, no dequeue
//   flush      discard held and incoming data, insert bubble
//   out_valid  main entry holds valid payload
//   out_ready  downstream accepts
//   out_data   main entry payload, BUBBLE_VAL when out_valid=0
//   occupancy  entries held (0..2)
//   stall_cnt  stall cycle count (PIPE_STAGE_PERF_EN only)
//   flush_cnt  flush event count (PIPE_STAGE_PERF_EN only)

module pipe_stage_skid_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              enq, deq;

    assign in_ready  = ~skid_valid_q & ~stall;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign enq = in_valid & in_ready & ~flush;
    assign deq = main_valid_q & out_ready & ~stall;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_VAL;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE_VAL;
        end else if (!stall) begin
            if (skid_valid_q) begin
                // Full: the skid entry is older than anything upstream, so it refills main.
                if (deq) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = BUBBLE_VAL;
                end
            end else if (main_valid_q) begin
                if (enq && deq) begin
                    main_data_d = in_data;
                end else if (enq) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end else if (deq) begin
                    main_valid_d = 1'b0;
                    main_data_d  = BUBBLE_VAL;
                end
            end else if (enq) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Counters saturate at all-ones; only rst clears them (flush does not).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Testbench for pipe_stage_skid_reg: a queue-based reference model of the stage contents,
// directed scenarios followed by random traffic, and a monitor that scores every delivery.
module tb_pipe_stage_skid_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUBBLE = '0;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    pipe_stage_skid_reg #(
        .DATA_W    (DATA_W),
        .BUBBLE_VAL(BUBBLE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .stall    (stall),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: payloads currently held by the stage, oldest first (capacity 2).
    logic [DATA_W-1:0] exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_delivered = 0;
    bit          checking = 1'b0;
    int unsigned stall_m = 0;
    int unsigned flush_m = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, check state against the model, push on enqueue.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic st, input logic fl, input logic r);
        int sz;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst       = r;
        #1;
        sz = exp_q.size();
        if (checking) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
            check("out_data", out_data, (sz > 0) ? exp_q[0] : BUBBLE);
            check("occupancy", {62'd0, occupancy}, DATA_W'(sz));
            check("in_ready", {63'd0, in_ready}, {63'd0, (sz < 2) && !st});
`ifdef PIPE_STAGE_PERF_EN
            check("stall_cnt", {60'd0, stall_cnt}, DATA_W'(stall_m));
            check("flush_cnt", {60'd0, flush_cnt}, DATA_W'(flush_m));
`endif
        end
        if (iv && sz < 2 && !st && !fl && !r) exp_q.push_back(d);
        if (r) begin
            stall_m = 0;
            flush_m = 0;
        end else begin
            if (fl && flush_m < 15) flush_m++;
            if (st && !fl && stall_m < 15) stall_m++;
        end
        @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
    endtask

    // Monitor: samples handshake away from the edge, scores the delivery at the edge.
    always begin
        logic v, ordy, st, fl, r;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        #2;
        v = out_valid; ordy = out_ready; st = stall; fl = flush; r = rst; d = out_data;
        @(posedge clk);
        if (r || fl) begin
            exp_q.delete();
        end else if (v && ordy && !st && checking) begin
            n_delivered++;
            if (exp_q.size() == 0) begin
                check("deliver_unexpected", d, BUBBLE);
            end else begin
                check("deliver", d, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset with traffic present
        cycle(1, 64'hDEAD, 1, 0, 0, 1);
        cycle(1, 64'hDEAD, 1, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 0);
        // Streaming
        cycle(1, 64'h1, 1, 0, 0, 0);
        cycle(1, 64'h2, 1, 0, 0, 0);
        cycle(1, 64'h3, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        // Backpressure then drain
        cycle(1, 64'hA, 0, 0, 0, 0);
        cycle(1, 64'hB, 0, 0, 0, 0);
        cycle(1, 64'hC, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        // Stall holding one entry
        cycle(1, 64'h5, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 64'h6, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        // Flush over stall with two entries held
        cycle(1, 64'h7, 0, 0, 0, 0);
        cycle(1, 64'h8, 0, 0, 0, 0);
        cycle(1, 64'h9, 1, 1, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        // Long stall (counter saturation when enabled)
        cycle(1, 64'h11, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 64'h12, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  {$urandom, $urandom},
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 199) == 0);
        end
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        n_checks++;
        if (n_delivered < 500) begin
            n_errors++;
            $display("FAIL deliveries: got %0d expected at least 500", n_delivered);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic successor to the fixed IF/ID pipeline register.
- Carries a DATA_W-bit payload (e.g. {pc4, instruction}) between any two pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so it sustains one transfer per cycle while downstream ready is a registered path.
- Keeps the hazard-unit stall and branch flush controls; a flush inserts a BUBBLE_VAL bubble (NOP).

Parameters:
- DATA_W, 64, payload width in bits.
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0; reset/flush value.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset (sampled on posedge clk only).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; = ~skid_valid & ~stall (combinational in stall only).
- in_data  in  DATA_W  upstream payload.
- stall  in  1  hazard hold; freezes the stage (no enqueue, no dequeue).
- flush  in  1  branch/exception flush; discards all held and incoming data.
- out_valid  out  1  main entry holds valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload; BUBBLE_VAL when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) stall cycle count.
- flush_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) flush event count.

Behaviour:
- Definitions:
  - enq = in_valid & in_ready & ~flush
  - deq = out_valid & out_ready & ~stall
- Priority order: rst > flush > stall > normal operation.
- Reset (rst=1 at posedge):
  - out_valid=0, skid_valid=0, occupancy=0.
  - out_data=BUBBLE_VAL, skid register=BUBBLE_VAL, counters=0.
  - Reset asserted mid-transfer drops both entries; nothing is delivered.
- Flush (rst=0, flush=1):
  - Same state result as reset, except the counters are not cleared.
  - in_data in the same cycle is dropped, even if in_valid=1.
  - Flush overrides stall.
- Stall (stall=1, flush=0):
  - All state holds; no enq, no deq.
  - in_ready=0; out_valid and out_data remain visible but are not consumed.
- States, encoded by occupancy:
  - EMPTY (0):
    - enq -> ONE, main<=in_data.
  - ONE (1):
    - enq & deq -> ONE, main<=in_data.
    - enq & ~deq -> TWO, skid<=in_data.
    - ~enq & deq -> EMPTY, out_data<=BUBBLE_VAL.
    - otherwise hold.
  - TWO (2), in_ready=0:
    - deq -> ONE, main<=skid, skid<=BUBBLE_VAL.
    - otherwise hold.
- Latency and throughput:
  - Data accepted at edge N appears on out_data after edge N (1-cycle latency).
  - Full throughput of 1 transfer/cycle when out_ready=1 and stall=0.
- Ordering: strict FIFO; the skid entry is always older than any later enqueue.
- Invariant: out_valid=0 implies out_data==BUBBLE_VAL and skid_valid=0.
- in_ready has no combinational path from out_ready (timing isolation); its only combinational input is stall.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle with stall=1 & flush=0 & rst=0.
  - flush_cnt increments on every cycle with flush=1 & rst=0.
  - Both counters saturate at all-ones and never wrap.
  - Both counters are cleared only by rst.
- Undefined:
  - stall_cnt and flush_cnt ports and their logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, with in_valid=1 and in_data=64'hDEAD -> out_valid=0, out_data=0, occupancy=0, in_ready=1 once rst=0.
- Streaming: out_ready=1; present 0x1, 0x2, 0x3 on consecutive cycles -> out_data shows 0x1, 0x2, 0x3 on the following consecutive cycles; occupancy stays 1; no bubbles.
- Backpressure: out_ready=0; send 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA, then 0xB delivered in order; in_ready=1 after the first deq.
- Stall: occupancy=1 holding 0x5; assert stall=1 for 3 cycles with in_valid=1, out_ready=1 -> out_data stays 0x5, in_ready=0, no consumption; with PERF_EN, stall_cnt=3.
- Flush: occupancy=2 (0x7, 0x8); assert flush=1 together with stall=1 and in_valid=1 (data 0x9) -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; 0x9 never appears; with PERF_EN, flush_cnt=1.
- Saturation (PERF_EN, CNT_W=4): hold stall=1 for 20 cycles -> stall_cnt=4'hF and remains 4'hF.
